// File: rtl/sprite_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_fetch_pkg
//  Description : Shared types and helpers for the sprite line fetcher:
//                fetch FSM state encoding, tile geometry constants and the
//                tile-map row base address helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sprite_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAP  = 3'd1,
        ST_IDX  = 3'd2,
        ST_WAIT = 3'd3,
        ST_WR   = 3'd4
    } fetch_state_t;

    // Tile geometry: 8 px wide, 16 lines tall, 2 bits per pixel.
    localparam int unsigned TILE_W = 8;
    localparam int unsigned TILE_H = 16;
    localparam int unsigned BPP    = 2;

    // First tile-map address of a tile row.
    function automatic logic [31:0] row_base(input logic [5:0] row,
                                             input int unsigned cols);
        return 32'(row) * cols;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_line_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_line_bank
//  Description : 2 x 128 x 16 simple dual-port line buffer. The fetcher
//                writes one bank while the pixel stage reads the other,
//                selected through the top address bit {bank, col[6:0]}.
//  Revision    : 1.0 - initial release
//  Ports       : clk      - system clock
//                i_we     - write enable
//                i_waddr  - write address {bank, col}
//                i_wdata  - sprite row data (8 px x 2 bpp)
//                i_raddr  - read address {bank, col}
//                o_rdata  - read data, one cycle after i_raddr
// ============================================================================
module sprite_line_bank
    import sprite_fetch_pkg::*;
(
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [7:0]              i_waddr,
    input  logic [TILE_W*BPP-1:0]   i_wdata,
    input  logic [7:0]              i_raddr,
    output logic [TILE_W*BPP-1:0]   o_rdata
);

    logic [TILE_W*BPP-1:0] r_mem [0:255];
    logic [TILE_W*BPP-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sprite_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_line_fetcher
//  Description : Per-scanline sequencer for the sprite store read port. On
//                each accepted line_start it walks one tile-map row:
//                map index -> sprite index -> 16-bit sprite row, and writes
//                each row into the write bank of the double-buffered line
//                buffer. Per column: MAP, IDX, SPR_LAT x WAIT, WR.
//  Revision    : 1.0 - initial release
//  Options     : SPRITE_FETCH_PERF_EN - adds perf_cycles, the number of busy
//                cycles of the last completed line (saturating).
//  Ports       : CLK_100/RESET_N  - clock, async active-low reset
//                line_start/line_y - start pulse and scanline to fetch
//                map_addr/map_rd/map_rdata - tile map read port
//                get_index/get_line/get_data - sprite store read port
//                buf_we/buf_waddr/buf_wdata - line buffer write port
//                disp_bank - bank the pixel stage reads
//                busy/done - fetch status, done is a one-cycle pulse
//                overrun/overrun_clr - sticky line_start-while-busy flag
// ============================================================================
module sprite_line_fetcher
    import sprite_fetch_pkg::*;
#(
    parameter int unsigned COLS    = 80,
    parameter int unsigned ROWS    = 30,
    parameter int unsigned MAP_AW  = 12,
    parameter int unsigned SPR_LAT = 1
) (
    input  logic              CLK_100,
    input  logic              RESET_N,
    input  logic              line_start,
    input  logic [9:0]        line_y,
    output logic [MAP_AW-1:0] map_addr,
    output logic              map_rd,
    input  logic [7:0]        map_rdata,
    output logic [7:0]        get_index,
    output logic [3:0]        get_line,
    input  logic [15:0]       get_data,
    output logic              buf_we,
    output logic [7:0]        buf_waddr,
    output logic [15:0]       buf_wdata,
    output logic              disp_bank,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    input  logic              overrun_clr
`ifdef SPRITE_FETCH_PERF_EN
    ,
    output logic [15:0]       perf_cycles
`endif
);

    localparam logic [6:0] c_last_col  = 7'(COLS - 1);
    localparam logic [7:0] c_wait_init = 8'(SPR_LAT - 1);

    fetch_state_t               r_state;
    logic                       r_bank;
    logic [$clog2(TILE_H)-1:0]  r_line;
    logic [MAP_AW-1:0]          r_base;
    logic [6:0]                 r_col;
    logic [7:0]                 r_wait_cnt;
    logic [MAP_AW-1:0]          r_map_addr;
    logic                       r_map_rd;
    logic [7:0]                 r_get_index;
    logic [3:0]                 r_get_line;
    logic                       r_buf_we;
    logic [7:0]                 r_buf_waddr;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_overrun;

    logic [MAP_AW-1:0]          w_base;
    logic                       w_row_ok;
    logic                       w_accept;

    assign w_base   = MAP_AW'(row_base(line_y[9:4], COLS));
    assign w_row_ok = (32'(line_y[9:4]) < ROWS);
    // busy is only ever high outside IDLE, so the state term is the guard.
    assign w_accept = line_start && !r_busy && (r_state == ST_IDLE);

    always_ff @(posedge CLK_100 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_bank      <= 1'b0;
            r_line      <= '0;
            r_base      <= '0;
            r_col       <= '0;
            r_wait_cnt  <= '0;
            r_map_addr  <= '0;
            r_map_rd    <= 1'b0;
            r_get_index <= '0;
            r_get_line  <= '0;
            r_buf_we    <= 1'b0;
            r_buf_waddr <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_map_rd <= 1'b0;
            r_buf_we <= 1'b0;
            r_done   <= 1'b0;

            // A new overrun event takes priority over a clear in the same cycle.
            if (line_start && r_busy) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_bank <= ~r_bank;
                        r_line <= line_y[3:0];
                        r_base <= w_base;
                        r_col  <= '0;
                        if (w_row_ok) begin
                            r_busy     <= 1'b1;
                            r_map_rd   <= 1'b1;
                            r_map_addr <= w_base;
                            r_state    <= ST_MAP;
                        end else begin
                            // Row below the map: nothing to fetch, finish at once.
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_MAP: begin
                    r_state <= ST_IDX;
                end
                ST_IDX: begin
                    r_get_index <= map_rdata;
                    r_get_line  <= r_line;
                    r_wait_cnt  <= c_wait_init;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 8'd0) begin
                        r_buf_we    <= 1'b1;
                        r_buf_waddr <= {r_bank, r_col};
                        r_state     <= ST_WR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 8'd1;
                    end
                end
                ST_WR: begin
                    if (r_col == c_last_col) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_col      <= r_col + 7'd1;
                        r_map_rd   <= 1'b1;
                        r_map_addr <= r_base + MAP_AW'(r_col + 7'd1);
                        r_state    <= ST_MAP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign map_addr  = r_map_addr;
    assign map_rd    = r_map_rd;
    assign get_index = r_get_index;
    assign get_line  = r_get_line;
    assign buf_we    = r_buf_we;
    assign buf_waddr = r_buf_waddr;
    // Sprite data is valid during WR only, so it is passed straight through.
    assign buf_wdata = get_data;
    assign disp_bank = ~r_bank;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overrun   = r_overrun;

`ifdef SPRITE_FETCH_PERF_EN
    logic [15:0] r_perf_cnt;
    logic [15:0] r_perf_cycles;

    always_ff @(posedge CLK_100 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_perf_cnt    <= '0;
            r_perf_cycles <= '0;
        end else begin
            if (w_accept) begin
                r_perf_cnt <= '0;
            end else if (r_busy && (r_perf_cnt != 16'hFFFF)) begin
                r_perf_cnt <= r_perf_cnt + 16'd1;
            end
            if (r_done) begin
                r_perf_cycles <= r_perf_cnt;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_line_fetcher
//  Description : Directed scoreboard bench for sprite_line_fetcher with a
//                tile-map model, a sprite-store model of matching latency and
//                the line buffer instantiated alongside. DUT 1 uses the
//                default geometry (SPR_LAT=1); DUT 2 uses COLS=8, SPR_LAT=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_line_fetcher;

    typedef struct packed {
        int          cyc;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [3:0]  line;
    } wr_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
        logic [3:0]  line;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // ---------------- DUT 1 ----------------
    logic        ls1, ovr_clr1;
    logic [9:0]  y1;
    logic [11:0] map_addr1;
    logic        map_rd1;
    logic [7:0]  map_rdata1;
    logic [7:0]  gi1;
    logic [3:0]  gl1;
    logic [15:0] gd1;
    logic        we1;
    logic [7:0]  wa1;
    logic [15:0] wd1;
    logic        db1, busy1, done1, ovr1;
    logic [15:0] perf1;

    sprite_line_fetcher #(.COLS(80), .ROWS(30), .MAP_AW(12), .SPR_LAT(1)) u_dut1 (
        .CLK_100(clk), .RESET_N(rst_n), .line_start(ls1), .line_y(y1),
        .map_addr(map_addr1), .map_rd(map_rd1), .map_rdata(map_rdata1),
        .get_index(gi1), .get_line(gl1), .get_data(gd1),
        .buf_we(we1), .buf_waddr(wa1), .buf_wdata(wd1),
        .disp_bank(db1), .busy(busy1), .done(done1),
        .overrun(ovr1), .overrun_clr(ovr_clr1)
`ifdef SPRITE_FETCH_PERF_EN
        , .perf_cycles(perf1)
`endif
    );

    logic [7:0]  rd_addr;
    logic [15:0] rd_data;

    sprite_line_bank u_bank (
        .clk(clk), .i_we(we1), .i_waddr(wa1), .i_wdata(wd1),
        .i_raddr(rd_addr), .o_rdata(rd_data)
    );

    // ---------------- DUT 2 ----------------
    logic        ls2, ovr_clr2;
    logic [9:0]  y2;
    logic [11:0] map_addr2;
    logic        map_rd2;
    logic [7:0]  map_rdata2;
    logic [7:0]  gi2;
    logic [3:0]  gl2;
    logic [15:0] gd2, s2;
    logic        we2;
    logic [7:0]  wa2;
    logic [15:0] wd2;
    logic        db2, busy2, done2, ovr2;
    logic [15:0] perf2;

    sprite_line_fetcher #(.COLS(8), .ROWS(30), .MAP_AW(12), .SPR_LAT(2)) u_dut2 (
        .CLK_100(clk), .RESET_N(rst_n), .line_start(ls2), .line_y(y2),
        .map_addr(map_addr2), .map_rd(map_rd2), .map_rdata(map_rdata2),
        .get_index(gi2), .get_line(gl2), .get_data(gd2),
        .buf_we(we2), .buf_waddr(wa2), .buf_wdata(wd2),
        .disp_bank(db2), .busy(busy2), .done(done2),
        .overrun(ovr2), .overrun_clr(ovr_clr2)
`ifdef SPRITE_FETCH_PERF_EN
        , .perf_cycles(perf2)
`endif
    );

    // ---------------- Models ----------------
    function automatic logic [15:0] spr_row(input logic [7:0] idx, input logic [3:0] ln);
        return {idx ^ 8'h5A, ~idx[3:0], ln};
    endfunction

    // Tile map: index = col + 0x80, valid only the cycle after map_rd.
    always @(posedge clk) begin
        map_rdata1 <= map_rd1 ? 8'(map_addr1 % 12'd80) + 8'h80 : 8'hEE;
        map_rdata2 <= map_rd2 ? 8'(map_addr2 % 12'd8)  + 8'h80 : 8'hEE;
        gd1 <= spr_row(gi1, gl1);
        s2  <= spr_row(gi2, gl2);
        gd2 <= s2;
    end

    // ---------------- Monitors ----------------
    wr_t wq1[$];
    wr_t wq2[$];
    int  mq1[$];
    int  mq2[$];
    int  dq1[$];
    int  dq2[$];

    always @(negedge clk) begin
        if (we1)     wq1.push_back('{cyc, wa1, wd1, gl1});
        if (map_rd1) mq1.push_back(int'(map_addr1));
        if (done1)   dq1.push_back(cyc);
        if (we2)     wq2.push_back('{cyc, wa2, wd2, gl2});
        if (map_rd2) mq2.push_back(int'(map_addr2));
        if (done2)   dq2.push_back(cyc);
    end

    // ---------------- Scoreboard ----------------
    exp_t exp_q[$];
    int   emap_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_line(input int cols, input int row, input int ln, input logic bank);
        for (int c = 0; c < cols; c++) begin
            exp_q.push_back('{{bank, 7'(c)}, spr_row(8'(c + 128), 4'(ln)), 4'(ln)});
            emap_q.push_back(row * cols + c);
        end
    endtask

    task automatic pulse(input int sel, input logic [9:0] y, output int t0);
        t0 = cyc;
        if (sel == 1) begin ls1 = 1'b1; y1 = y; end
        else          begin ls2 = 1'b1; y2 = y; end
        @(posedge clk); #1;
        ls1 = 1'b0;
        ls2 = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int limit);
        for (int i = 0; i < limit && ((sel == 1) ? dq1.size() : dq2.size()) == 0; i++) begin
            @(posedge clk); #1;
        end
        check("done seen", ((sel == 1) ? dq1.size() : dq2.size()) > 0 ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic verify(input string tag, input int sel, input int spacing);
        wr_t o[$];
        int  m[$];
        if (sel == 1) begin o = wq1; m = mq1; end
        else          begin o = wq2; m = mq2; end
        check($sformatf("%s write count", tag), o.size(), exp_q.size());
        for (int i = 0; i < o.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s w%0d addr", tag, i), o[i].addr, exp_q[i].addr);
            check($sformatf("%s w%0d data", tag, i), o[i].data, exp_q[i].data);
            check($sformatf("%s w%0d line", tag, i), o[i].line, exp_q[i].line);
            if (i > 0)
                check($sformatf("%s w%0d spacing", tag, i), o[i].cyc - o[i-1].cyc, spacing);
        end
        check($sformatf("%s map count", tag), m.size(), emap_q.size());
        for (int i = 0; i < m.size() && i < emap_q.size(); i++)
            check($sformatf("%s map%0d addr", tag, i), m[i], emap_q[i]);
        exp_q.delete();
        emap_q.delete();
    endtask

    task automatic clear_mon();
        wq1.delete(); wq2.delete();
        mq1.delete(); mq2.delete();
        dq1.delete(); dq2.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- Stimulus ----------------
    initial begin
        int t0;
        rst_n = 1'b0;
        ls1 = 1'b0; ls2 = 1'b0; y1 = '0; y2 = '0;
        ovr_clr1 = 1'b0; ovr_clr2 = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst busy", busy1, 0);
        check("rst buf_we", we1, 0);
        check("rst done", done1, 0);
        check("rst overrun", ovr1, 0);
        check("rst map_rd", map_rd1, 0);
        check("rst map_addr", map_addr1, 0);
        check("rst get_index", gi1, 0);
        check("rst disp_bank", db1, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a fetch, at column 5
        pulse(1, 10'd35, t0);
        for (int i = 0; i < 200 && wq1.size() < 5; i++) begin
            @(posedge clk); #1;
        end
        check("abort reached col5", wq1.size(), 5);
        #1 rst_n = 1'b0;
        #1;
        check("abort busy", busy1, 0);
        check("abort buf_we", we1, 0);
        check("abort map_rd", map_rd1, 0);
        check("abort disp_bank", db1, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort no more writes", wq1.size(), 5);
        clear_mon();

        // Full line: row 2, line 3, written to bank 1
        expect_line(80, 2, 3, 1'b1);
        pulse(1, 10'd35, t0);
        wait_done(1, 400);
        if (dq1.size() > 0) check("main done latency", dq1[0] - t0, 321);
        verify("main", 1, 4);
        check("main disp_bank", db1, 0);
        check("main busy after", busy1, 0);
        @(posedge clk); #1;
`ifdef SPRITE_FETCH_PERF_EN
        check("main perf_cycles", perf1, 320);
`endif
        rd_addr = 8'h80;
        @(posedge clk); #1;
        check("bank rd col0", rd_data, spr_row(8'h80, 4'd3));
        rd_addr = 8'h80 + 8'd79;
        @(posedge clk); #1;
        check("bank rd col79", rd_data, spr_row(8'h80 + 8'd79, 4'd3));
        clear_mon();

        // Row past the end of the map
        pulse(1, 10'd480, t0);
        repeat (5) @(posedge clk);
        #1;
        check("oor done count", dq1.size(), 1);
        if (dq1.size() > 0) check("oor done latency", dq1[0] - t0, 1);
        check("oor writes", wq1.size(), 0);
        check("oor map reads", mq1.size(), 0);
        check("oor disp_bank", db1, 1);
        clear_mon();

        // line_start while busy
        check("ovr initial", ovr1, 0);
        expect_line(80, 2, 3, 1'b1);
        pulse(1, 10'd35, t0);
        repeat (9) @(posedge clk);
        #1;
        ls1 = 1'b1; y1 = 10'd80;
        @(posedge clk); #1;
        ls1 = 1'b0;
        check("ovr set", ovr1, 1);
        wait_done(1, 400);
        if (dq1.size() > 0) check("ovr done latency", dq1[0] - t0, 321);
        verify("ovr", 1, 4);
        check("ovr sticky", ovr1, 1);
        ovr_clr1 = 1'b1;
        @(posedge clk); #1;
        ovr_clr1 = 1'b0;
        check("ovr cleared", ovr1, 0);
        clear_mon();

        // Clear and overrun in the same cycle: set wins
        expect_line(80, 2, 3, 1'b0);
        pulse(1, 10'd35, t0);
        repeat (5) @(posedge clk);
        #1;
        ls1 = 1'b1; ovr_clr1 = 1'b1;
        @(posedge clk); #1;
        ls1 = 1'b0; ovr_clr1 = 1'b0;
        check("ovr set beats clr", ovr1, 1);
        wait_done(1, 400);
        verify("ovr2", 1, 4);
        clear_mon();

        // SPR_LAT=2 instance: row 5, line 7
        expect_line(8, 5, 7, 1'b1);
        pulse(2, 10'd87, t0);
        wait_done(2, 200);
        if (dq2.size() > 0) check("lat2 done latency", dq2[0] - t0, 41);
        verify("lat2", 2, 5);
        @(posedge clk); #1;
`ifdef SPRITE_FETCH_PERF_EN
        check("lat2 perf_cycles", perf2, 40);
`endif
        clear_mon();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
